// File: rtl/filter_mode_sequencer.sv
// Filter mode sequencer: debounced "next" button, frame-aligned filter switching.
// Optional slideshow cycling is built when FILTER_AUTO_CYCLE_EN is defined.
module filter_mode_sequencer #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_next,
    input  logic       i_sw_enable,
    input  logic       i_auto_mode,
    input  logic       i_frame_start,
    output logic [1:0] o_filter_sel,
    output logic       o_invert_en,
    output logic       o_pending,
    output logic [1:0] o_mode_idx
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       LAST_MODE = 2'(NUM_MODES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_btnMeta;
    logic             r_btnSync;
    logic             r_swMeta;
    logic             r_swSync;
    logic             r_btnDeb;
    logic             r_btnDebD;
    logic [DEB_W-1:0] r_debCnt;
    logic [1:0]       r_modeIdx;
    logic [1:0]       r_filterSel;
    logic             r_invertEn;
    logic             r_pending;

    logic             w_btnReq;
    logic             w_autoReq;
    logic             w_request;
    logic [1:0]       w_nextMode;
    logic [1:0]       w_newMode;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btnMeta <= 1'b0;
            r_btnSync <= 1'b0;
            r_swMeta  <= 1'b0;
            r_swSync  <= 1'b0;
        end else begin
            r_btnMeta <= i_btn_next;
            r_btnSync <= r_btnMeta;
            r_swMeta  <= i_sw_enable;
            r_swSync  <= r_swMeta;
        end
    end

    // The debounced level only follows the synced button after it has disagreed
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btnDeb  <= 1'b0;
            r_btnDebD <= 1'b0;
            r_debCnt  <= '0;
        end else begin
            r_btnDebD <= r_btnDeb;
            if (r_btnSync == r_btnDeb) begin
                r_debCnt <= '0;
            end else if (r_debCnt == DEB_LAST) begin
                r_btnDeb <= r_btnSync;
                r_debCnt <= '0;
            end else begin
                r_debCnt <= r_debCnt + 1'b1;
            end
        end
    end

    assign w_btnReq = r_btnDeb & ~r_btnDebD;

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int AF_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [AF_W-1:0] AUTO_LAST = AF_W'(AUTO_FRAMES - 1);

    logic            r_autoMeta;
    logic            r_autoSync;
    logic [AF_W-1:0] r_frameCnt;

    // Frames are only counted while nothing is queued, so the frame that applies
    // an auto advance is not counted towards the next one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_autoMeta <= 1'b0;
            r_autoSync <= 1'b0;
            r_frameCnt <= '0;
        end else begin
            r_autoMeta <= i_auto_mode;
            r_autoSync <= r_autoMeta;
            if (!r_autoSync) begin
                r_frameCnt <= '0;
            end else if (i_frame_start && (r_state == IDLE)) begin
                if (r_frameCnt == AUTO_LAST) begin
                    r_frameCnt <= '0;
                end else begin
                    r_frameCnt <= r_frameCnt + 1'b1;
                end
            end
        end
    end

    assign w_autoReq = r_autoSync & i_frame_start & (r_state == IDLE) &
                       (r_frameCnt == AUTO_LAST);
`else
    logic w_unusedAuto;
    assign w_unusedAuto = i_auto_mode;
    assign w_autoReq    = 1'b0;
`endif

    assign w_request  = w_btnReq | w_autoReq;
    assign w_nextMode = (r_modeIdx == LAST_MODE) ? 2'd0 : r_modeIdx + 2'd1;
    assign w_newMode  = ((r_state == PENDING) && i_frame_start) ? w_nextMode : r_modeIdx;

    // Mode advances and filter outputs only ever change on a frame_start cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_modeIdx   <= 2'd0;
            r_filterSel <= 2'd0;
            r_invertEn  <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_request) begin
                        r_state   <= PENDING;
                        r_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (i_frame_start) begin
                        r_state   <= IDLE;
                        r_pending <= 1'b0;
                        r_modeIdx <= w_nextMode;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b0;
                end
            endcase
            if (i_frame_start) begin
                r_filterSel <= r_swSync ? w_newMode : 2'd0;
                r_invertEn  <= r_swSync && (w_newMode == 2'd1);
            end
        end
    end

    assign o_filter_sel = r_filterSel;
    assign o_invert_en  = r_invertEn;
    assign o_pending    = r_pending;
    assign o_mode_idx   = r_modeIdx;

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Bench for filter_mode_sequencer: per-cycle behavioural model plus directed literal checks.
// Honours FILTER_AUTO_CYCLE_EN to match the slideshow build.
module tb_filter_mode_sequencer;

    localparam int DEB       = 4;
    localparam int AUTO      = 3;
    localparam int NMODES    = 4;
    localparam int FRAME_GAP = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnNext;
    logic       swEnable;
    logic       autoMode;
    logic       frameStart;
    logic [1:0] filterSel;
    logic [1:0] modeIdx;
    logic       invertEn;
    logic       pendingOut;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    filter_mode_sequencer #(
        .NUM_MODES      (NMODES),
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_FRAMES    (AUTO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_btn_next   (btnNext),
        .i_sw_enable  (swEnable),
        .i_auto_mode  (autoMode),
        .i_frame_start(frameStart),
        .o_filter_sel (filterSel),
        .o_invert_en  (invertEn),
        .o_pending    (pendingOut),
        .o_mode_idx   (modeIdx)
    );

    // Model state: raw input history gives the 2-cycle synchroniser delay,
    // a window of recent synced samples gives the debounce rule.
    bit   mValid = 1'b0;
    bit   mBtnHist[2];
    bit   mSwHist[2];
    bit   mAutoHist[2];
    bit   mWin[$];
    bit   mDeb;
    bit   mReqNext;
    bit   mPend;
    int   mMode;
    int   mSel;
    bit   mInv;
    int   mFrameCnt;

    task automatic checkValue(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expMode,
                               input logic [1:0] expSel, input logic expInv,
                               input logic expPend);
        checkValue({name, ".mode_idx"},   modeIdx,           expMode);
        checkValue({name, ".filter_sel"}, filterSel,         expSel);
        checkValue({name, ".invert_en"},  {1'b0, invertEn},   {1'b0, expInv});
        checkValue({name, ".pending"},    {1'b0, pendingOut}, {1'b0, expPend});
    endtask

    task automatic applyStimulus(input logic btn, input logic sw, input logic autoIn,
                                 input logic fs, input int cycles);
        btnNext    = btn;
        swEnable   = sw;
        autoMode   = autoIn;
        frameStart = fs;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic modelStep();
        bit btnS;
        bit swS;
        bit req;
        bit allDiff;
        if (reset) begin
            mBtnHist  = '{0, 0};
            mSwHist   = '{0, 0};
            mAutoHist = '{0, 0};
            mWin.delete();
            mDeb      = 1'b0;
            mReqNext  = 1'b0;
            mPend     = 1'b0;
            mMode     = 0;
            mSel      = 0;
            mInv      = 1'b0;
            mFrameCnt = 0;
            mValid    = 1'b1;
            return;
        end
        btnS = mBtnHist[1];
        swS  = mSwHist[1];
`ifdef FILTER_AUTO_CYCLE_EN
        begin
            bit autoS;
            autoS = mAutoHist[1];
            req   = mReqNext;
            if (!autoS) begin
                mFrameCnt = 0;
            end else if (frameStart && !mPend) begin
                if (mFrameCnt == AUTO - 1) begin
                    mFrameCnt = 0;
                    req = 1'b1;
                end else begin
                    mFrameCnt++;
                end
            end
        end
`else
        req = mReqNext;
`endif
        mBtnHist[1]  = mBtnHist[0];
        mBtnHist[0]  = btnNext;
        mSwHist[1]   = mSwHist[0];
        mSwHist[0]   = swEnable;
        mAutoHist[1] = mAutoHist[0];
        mAutoHist[0] = autoMode;

        mWin.push_back(btnS);
        if (mWin.size() > DEB) void'(mWin.pop_front());
        mReqNext = 1'b0;
        if (mWin.size() == DEB) begin
            allDiff = 1'b1;
            foreach (mWin[i]) if (mWin[i] == mDeb) allDiff = 1'b0;
            if (allDiff) begin
                mReqNext = !mDeb;
                mDeb     = !mDeb;
            end
        end

        if (frameStart && mPend) begin
            mMode = (mMode + 1) % NMODES;
            mPend = 1'b0;
        end else if (!mPend && req) begin
            mPend = 1'b1;
        end
        if (frameStart) begin
            mSel = swS ? mMode : 0;
            mInv = (mSel == 1);
        end
    endtask

    always @(posedge clk) begin
        modelStep();
        #1;
        if (mValid) begin
            checkValue("cyc.mode_idx",   modeIdx,            2'(mMode));
            checkValue("cyc.filter_sel", filterSel,          2'(mSel));
            checkValue("cyc.invert_en",  {1'b0, invertEn},   {1'b0, mInv});
            checkValue("cyc.pending",    {1'b0, pendingOut}, {1'b0, mPend});
        end
    end

    logic [1:0] expMode[4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        reset      = 1'b1;
        btnNext    = 1'b1;
        swEnable   = 1'b1;
        autoMode   = 1'b1;
        frameStart = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", 2'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("after_reset", 2'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0, 4);

        // Press-to-pending latency: nothing after 6 edges, queued on the 7th.
        applyStimulus(1, 1, 0, 0, 6);
        checkOutput("press_lat6", 2'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("press_lat7", 2'd0, 2'd0, 1'b0, 1'b1);
        applyStimulus(1, 1, 0, 0, 13);
        applyStimulus(0, 1, 0, 0, 20);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("first_frame", 2'd1, 2'd1, 1'b1, 1'b0);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 2);
            applyStimulus(0, 1, 0, 0, 2);
        end
        applyStimulus(0, 1, 0, 0, 20);
        checkOutput("bounce", 2'd1, 2'd1, 1'b1, 1'b0);

        applyStimulus(1, 1, 0, 0, 10);
        applyStimulus(0, 1, 0, 0, 10);
        checkOutput("queued", 2'd1, 2'd1, 1'b1, 1'b1);
        reset = 1'b1;
        applyStimulus(0, 1, 0, 0, 2);
        reset = 1'b0;
        applyStimulus(0, 1, 0, 0, 3);
        checkOutput("reset_pending", 2'd0, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 10);
            applyStimulus(0, 1, 0, 0, FRAME_GAP - 11);
            applyStimulus(0, 1, 0, 1, 1);
            checkOutput("step_mode", expMode[i], expMode[i], expMode[i] == 2'd1, 1'b0);
        end

        // Two presses in one frame coalesce into a single advance.
        applyStimulus(1, 1, 0, 0, 10);
        applyStimulus(0, 1, 0, 0, 10);
        applyStimulus(1, 1, 0, 0, 10);
        applyStimulus(0, 1, 0, 0, 10);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("coalesce", 2'd1, 2'd1, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0, 10);
        checkOutput("sw_off_hold", 2'd1, 2'd1, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0, FRAME_GAP - 11);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("sw_off_frame", 2'd1, 2'd0, 1'b0, 1'b0);

        // Request and frame_start on the same edge: queued, applied one frame later.
        applyStimulus(1, 0, 0, 0, 6);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("req_and_frame", 2'd1, 2'd0, 1'b0, 1'b1);
        applyStimulus(0, 0, 0, 0, 20);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("apply_next_frame", 2'd2, 2'd0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0, FRAME_GAP - 1);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("sw_on", 2'd2, 2'd2, 1'b0, 1'b0);

        applyStimulus(0, 1, 1, 0, 5);
        for (int f = 1; f <= 4; f++) begin
            applyStimulus(0, 1, 1, 0, FRAME_GAP - 1);
            applyStimulus(0, 1, 1, 1, 1);
            if (f == 3) begin
`ifdef FILTER_AUTO_CYCLE_EN
                checkOutput("auto_queued", 2'd2, 2'd2, 1'b0, 1'b1);
`else
                checkOutput("auto_queued", 2'd2, 2'd2, 1'b0, 1'b0);
`endif
            end
        end
`ifdef FILTER_AUTO_CYCLE_EN
        checkOutput("auto_applied", 2'd3, 2'd3, 1'b0, 1'b0);
`else
        checkOutput("auto_applied", 2'd2, 2'd2, 1'b0, 1'b0);
`endif
        applyStimulus(0, 1, 0, 0, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
